// File: rtl/ifu_fetch.sv
// ifu_fetch: owns the PC, issues in-order imem requests,
// buffers returned words and redirects on branch/jump.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic [1:0]  npc_op
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   buf_inst [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] inflight_nxt;
  logic          run;

  logic          consume;
  logic          redirect;
  logic          issue;
  logic          resp;
  logic          push;
  logic [31:0]   pc_plus4;
  logic [31:0]   br_tgt;
  logic [31:0]   jmp_tgt;
  logic [31:0]   target;

  assign inst_valid = count != '0;
  assign inst       = inst_valid ? buf_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? buf_pc[rd_ptr] : '0;
  assign consume    = inst_valid & inst_ready;

  assign pc_plus4 = inst_pc + 32'd4;
  assign br_tgt   = pc_plus4 +
                    {{14{inst[15]}}, inst[15:0], 2'b00};
  assign jmp_tgt  = {pc_plus4[31:28], inst[25:0], 2'b00};

  always_comb begin
    redirect = 1'b0;
    target   = pc_plus4;
    if (consume) begin
      unique case (npc_op)
        2'b01: begin
          redirect = 1'b1;
          target   = br_tgt;
        end
        2'b10: begin
          redirect = 1'b1;
          target   = jmp_tgt;
        end
        default: ;
      endcase
    end
  end

  // credit: buffered + in-flight never exceeds DEPTH
  assign imem_req  = run & ~redirect &
                     (({1'b0, count} + {1'b0, inflight}) < CAP);
  assign imem_addr = fetch_pc;
  assign issue     = imem_req & imem_gnt;
  assign resp      = imem_rvalid & (inflight != '0);
  assign push      = resp & (drop == '0) & ~redirect;

  assign inflight_nxt = inflight + CW'(issue) - CW'(resp);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= inflight_nxt;
      if (redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= inflight_nxt;
      end else begin
        if (issue)
          fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (consume)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(consume);
        if (resp && drop != '0)
          drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]   <= resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push)
      assert (count < CW'(DEPTH));
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: random imem/consumer stimulus checked
// against an architectural PC-stream reference model.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [1:0]  npc_op;

  ifu_fetch #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .npc_op     (npc_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] ovr   [logic [31:0]];
  logic [1:0]  op_at [logic [31:0]];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int gnt_pct, rv_pct, rdy_pct, br_pct;
  int lat_min, lat_max;
  int hold8 = 0;
  int n_cons, n_issue, n_req8;
  int n_at10, n_at400, n_atfffc;
  logic [31:0] exp_pc;
  logic [31:0] first_pc;
  logic [31:0] hold_addr;
  logic [31:0] chk_addr;
  logic        hold_valid;
  logic        chk_addr_valid;
  logic        last_req;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr.exists(a))
      return ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // architectural next-PC from the instruction word
  function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                          input logic [31:0] w,
                                          input logic [1:0]  op);
    logic [31:0] seq;
    logic [31:0] off;
    seq = pc + 32'd4;
    off = 32'($signed(w[15:0]));
    off = off * 4;
    if (op == 2'b01)
      return seq + off;
    if (op == 2'b10)
      return (seq & 32'hF000_0000) | (32'(w[25:0]) * 4);
    return seq;
  endfunction

  task automatic clear_model();
    pq.delete();
    op_at.delete();
    exp_pc         = RESET_PC;
    hold_valid     = 1'b0;
    chk_addr_valid = 1'b0;
    n_cons   = 0;
    n_issue  = 0;
    n_req8   = 0;
    n_at10   = 0;
    n_at400  = 0;
    n_atfffc = 0;
    first_pc = 32'hFFFF_FFFF;
  endtask

  task automatic do_reset(input bit stale);
    rstn        = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;
    npc_op      = 2'b00;
    repeat (2) begin
      @(negedge clk);
      cyc++;
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_pc", inst_pc, 32'd0);
    end
    @(negedge clk);
    cyc++;
    rstn = 1'b1;
    if (stale && pq.size() != 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      void'(pq.pop_front());
    end
    #1;
    chk("rst_req_lo", 32'(imem_req), 32'd0);
    @(negedge clk);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (stale && pq.size() != 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      void'(pq.pop_front());
    end
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    clear_model();
  endtask

  task automatic cycle();
    logic [1:0]  op;
    logic [31:0] w;
    logic [31:0] tgt;
    @(negedge clk);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pq.size() != 0 && pq[0].due <= cyc &&
        $urandom_range(99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pq[0].addr);
      void'(pq.pop_front());
    end
    inst_ready = $urandom_range(99) < rdy_pct;
    if (op_at.exists(exp_pc))
      op = op_at[exp_pc];
    else if ($urandom_range(99) < br_pct)
      op = 2'($urandom_range(3, 1));
    else
      op = 2'b00;
    npc_op = op;
    #1;
    imem_gnt = $urandom_range(99) < gnt_pct;
    if (imem_req && imem_addr == 32'h8 && hold8 > 0) begin
      imem_gnt = 1'b0;
      hold8--;
    end
    #1;
    if (chk_addr_valid) begin
      chk("redir_addr", imem_addr, chk_addr);
      chk_addr_valid = 1'b0;
    end
    if (imem_req) begin
      chk("align", 32'(imem_addr[1:0]), 32'd0);
      if (hold_valid)
        chk("addr_hold", imem_addr, hold_addr);
      if (imem_addr == 32'h8)
        n_req8++;
    end
    hold_valid = imem_req && !imem_gnt;
    hold_addr  = imem_addr;
    last_req   = imem_req;
    if (imem_req && imem_gnt) begin
      pq.push_back('{imem_addr,
                     cyc + $urandom_range(lat_max, lat_min)});
      n_issue++;
    end
    if (inst_valid && inst_ready) begin
      w = mem_word(exp_pc);
      chk("pc", inst_pc, exp_pc);
      chk("inst", inst, w);
      if (n_cons == 0)
        first_pc = inst_pc;
      n_cons++;
      if (exp_pc == 32'h10)        n_at10++;
      if (exp_pc == 32'h400)       n_at400++;
      if (exp_pc == 32'hFFFF_FFFC) n_atfffc++;
      tgt = next_pc(exp_pc, w, op);
      if (op == 2'b01 || op == 2'b10) begin
        chk("redir_req", 32'(imem_req), 32'd0);
        chk_addr       = tgt;
        chk_addr_valid = 1'b1;
      end
      if (op_at.exists(exp_pc))
        op_at.delete(exp_pc);
      exp_pc = tgt;
    end
  endtask

  task automatic run_until(input string tag,
                           input int n,
                           input int budget);
    int k;
    k = 0;
    while (n_cons < n && k < budget) begin
      cycle();
      k++;
    end
    chk(tag, 32'(n_cons >= n), 32'd1);
  endtask

  task automatic set_env(input int g, input int rv,
                         input int rd, input int br,
                         input int lmin, input int lmax);
    gnt_pct = g;
    rv_pct  = rv;
    rdy_pct = rd;
    br_pct  = br;
    lat_min = lmin;
    lat_max = lmax;
  endtask

  initial begin
    ovr[32'h0]         = {6'h04, 10'h0, 16'hFFFE};
    ovr[32'h4]         = {6'h02, 26'h010_0008};
    ovr[32'h10]        = {6'h04, 10'h0, 16'hFFFF};
    ovr[32'h0040_0020] = {6'h03, 26'h000_0100};
    set_env(100, 100, 100, 0, 1, 1);

    // sequential stream from reset
    do_reset(1'b0);
    run_until("t1_stream", 10, 100);

    // back-pressure: credit caps issues at DEPTH
    do_reset(1'b0);
    set_env(100, 100, 0, 0, 1, 1);
    repeat (12) cycle();
    chk("t2_issues", 32'(n_issue), 32'(DEPTH));
    chk("t2_req_lo", 32'(last_req), 32'd0);
    rdy_pct = 100;
    run_until("t2_resume", 10, 100);

    // backward branch across address zero
    do_reset(1'b0);
    op_at[32'h0] = 2'b01;
    run_until("wrap_run", 8, 200);
    chk("wrap_seen", 32'(n_atfffc), 32'd1);

    // self-branch at 0x10 with wrong-path words
    do_reset(1'b0);
    set_env(100, 100, 100, 0, 3, 3);
    op_at[32'h10] = 2'b01;
    run_until("t3_run", 12, 300);
    chk("t3_at10", 32'(n_at10), 32'd2);

    // two jumps: 0x4 -> 0x400020 -> 0x400
    do_reset(1'b0);
    set_env(100, 100, 100, 0, 1, 2);
    op_at[32'h4]         = 2'b10;
    op_at[32'h0040_0020] = 2'b10;
    run_until("t4_run", 8, 200);
    chk("t4_at400", 32'(n_at400), 32'd1);

    // grant stall on 0x8 and long latency
    do_reset(1'b0);
    set_env(100, 100, 100, 0, 5, 5);
    hold8 = 3;
    run_until("t5_run", 8, 300);
    chk("t5_req8", 32'(n_req8), 32'd4);

    // reset with two requests outstanding
    do_reset(1'b0);
    set_env(100, 100, 0, 0, 6, 6);
    for (int k = 0; k < 20 && pq.size() < 2; k++)
      cycle();
    chk("t6_pend", 32'(pq.size()), 32'd2);
    do_reset(1'b1);
    set_env(100, 100, 100, 0, 1, 1);
    run_until("t6_run", 6, 100);
    chk("t6_first_pc", first_pc, RESET_PC);

    // random traffic, random redirects
    do_reset(1'b0);
    set_env(70, 70, 60, 25, 1, 4);
    repeat (3000) cycle();
    chk("rand_progress", 32'(n_cons > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
